// File: rtl/slink_apb_target_if.sv
// APB bus bundle between the S-Link initiator and a register completer.
interface slink_apb_target_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] apb_paddr;
  logic                  apb_pwrite;
  logic                  apb_psel;
  logic                  apb_penable;
  logic [31:0]           apb_pwdata;
  logic [31:0]           apb_prdata;
  logic                  apb_pready;
  logic                  apb_pslverr;

  modport master (
    output apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr
  );

  modport slave (
    input  apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/slink_apb_target.sv
// APB completer: NUM_REGS RW words, a read-only status word and a sticky
// W1C event word with interrupt. Configurable wait states; error response
// for unmapped, misaligned and status-write accesses.
module slink_apb_target #(
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                     apb_clk,
  input  logic                     apb_reset,
  slink_apb_target_if.slave        apb,
  input  logic [31:0]              status_in,
  input  logic [31:0]              event_in,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic                     irq
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t                      r_state, w_next;
  logic [31:0]                 r_idx;
  logic                        r_write;
  logic [31:0]                 r_wdata;
  logic                        r_err;
  logic [2:0]                  r_cnt;
  logic [31:0]                 r_prdata;
  logic [NUM_REGS-1:0][31:0]   r_regs;
  logic [31:0]                 r_ev;
  logic                        r_irq;

  logic [31:0] w_idx;
  logic        w_setup, w_acc, w_done, w_viol, w_err, w_commit;
  logic [31:0] w_rdata, w_clr, w_ev_nxt;

  // Word index of the presented address, widened so it compares cleanly
  // against the integer decode limits.
  assign w_idx   = 32'(apb.apb_paddr[ADDR_WIDTH-1:2]);
  assign w_setup = apb.apb_psel & ~apb.apb_penable;
  assign w_acc   = apb.apb_psel &  apb.apb_penable;
  assign w_done  = (r_state == ACCESS) & w_acc & (r_cnt == WS);
  // Access phase without a preceding setup: answer with an error, touch nothing.
  assign w_viol  = (r_state == IDLE) & w_acc;
  assign w_commit = w_done & r_write & ~r_err;

  // pready/pslverr are combinational so a zero-wait transfer takes two cycles;
  // held low while reset is asserted.
  assign apb.apb_pready  = ~apb_reset & (w_done | w_viol);
  assign apb.apb_pslverr = ~apb_reset & ((w_done & r_err) | w_viol);
  assign apb.apb_prdata  = r_prdata;
  assign regs_out        = r_regs;
  assign irq             = r_irq;

  // Decode the error flag and the read data for the transfer in setup.
  always_comb begin
    w_err   = (apb.apb_paddr[1:0] != 2'b00) ||
              (w_idx > NUM_REGS + 1) ||
              ((w_idx == NUM_REGS) && apb.apb_pwrite);
    w_rdata = '0;
    if (!w_err && !apb.apb_pwrite) begin
      if (w_idx < NUM_REGS) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (w_idx == i) w_rdata = r_regs[i];
      end else if (w_idx == NUM_REGS) begin
        w_rdata = status_in;
      end else begin
        w_rdata = r_ev;
      end
    end
  end

  // Event word update: clear from a committed W1C write, new events win.
  always_comb begin
    w_clr    = (w_commit && (r_idx == NUM_REGS + 1)) ? r_wdata : '0;
    w_ev_nxt = (r_ev & ~w_clr) | event_in;
  end

  // Next-state logic: setup starts a transfer, psel drop aborts, pready ends it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next = ACCESS;
      ACCESS:  if (!apb.apb_psel || w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Transfer capture at setup and wait-state counting during access.
  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_prdata <= '0;
    end else if (r_state == IDLE && w_setup) begin
      r_idx    <= w_idx;
      r_write  <= apb.apb_pwrite;
      r_wdata  <= apb.apb_pwdata;
      r_err    <= w_err;
      r_cnt    <= '0;
      r_prdata <= w_rdata;
    end else if (r_state == ACCESS && w_acc && r_cnt < WS) begin
      r_cnt    <= r_cnt + 3'd1;
    end
  end

  // RW registers commit on the completing edge.
  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_commit && r_idx == i) r_regs[i] <= r_wdata;
    end
  end

  // Sticky events and the registered interrupt.
  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      r_ev  <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ev  <= w_ev_nxt;
      r_irq <= |w_ev_nxt;
    end
  end

endmodule
